// File: rtl/router_pkt_source_pkg.sv
// Shared definitions for the router packet source: header field widths,
// FSM state encoding and the header byte builder.
package router_pkt_source_pkg;

   localparam int HDR_LEN_W   = 6;
   localparam int HDR_ADDR_W  = 2;
   localparam int MAX_LEN_DEF = (1 << HDR_LEN_W) - 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_PAYLOAD,
      ST_PARITY,
      ST_GAP
   } pkt_state_e;

   function automatic logic [7:0] mk_header(input logic [HDR_LEN_W-1:0]  len,
                                            input logic [HDR_ADDR_W-1:0] addr);
      return {len, addr};
   endfunction

endpackage

// File: rtl/router_pkt_source_if.sv
// Payload-load, request and router-side signals of the packet source.
interface router_pkt_source_if;
   import router_pkt_source_pkg::*;

   logic                  wr_en;
   logic [7:0]            wr_data;
   logic                  wr_ready;
   logic                  start;
   logic [HDR_ADDR_W-1:0] dest_addr;
   logic [HDR_LEN_W-1:0]  payload_len;
   logic                  corrupt_parity;
   logic                  busy;
   logic                  pkt_valid;
   logic [7:0]            data_out;
   logic                  done;
   logic                  req_err;

   modport master (
      input  wr_en, wr_data, start, dest_addr, payload_len, corrupt_parity, busy,
      output wr_ready, pkt_valid, data_out, done, req_err
   );

   modport slave (
      output wr_en, wr_data, start, dest_addr, payload_len, corrupt_parity, busy,
      input  wr_ready, pkt_valid, data_out, done, req_err
   );

endinterface

// File: rtl/router_pkt_source_buf.sv
// Payload byte store: sequential writes at the count pointer, combinational
// read by index, synchronous clear once a packet has gone out.
module pkt_byte_buffer
   import router_pkt_source_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 wr_en,
   input  logic [7:0]           wr_data,
   input  logic [HDR_LEN_W-1:0] rd_idx,
   output logic [7:0]           rd_data,
   output logic [HDR_LEN_W-1:0] count
);

   localparam logic [HDR_LEN_W-1:0] MAX_CNT = HDR_LEN_W'(MAX_LEN);

   logic [7:0] mem [MAX_LEN];
   logic       wr_ok;

   assign wr_ok   = wr_en && !clr && !rst && (count < MAX_CNT);
   assign rd_data = mem[rd_idx];

   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (wr_ok)
         count <= count + 1'b1;
   end

   // Storage is not reset: an empty buffer is defined by count alone.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[count] <= wr_data;
   end

endmodule

// File: rtl/router_pkt_source.sv
// Router input-port traffic source: header, payload from the buffer, parity,
// one gap cycle; every beat holds while the router reports busy.
module router_pkt_source
   import router_pkt_source_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF
) (
   input  logic                clk,
   input  logic                rst,
   router_pkt_source_if.master bus
);

   localparam logic [HDR_LEN_W-1:0] MAX_CNT = HDR_LEN_W'(MAX_LEN);

   pkt_state_e            state, state_n;
   logic [HDR_LEN_W-1:0]  len_q, len_n;
   logic [HDR_ADDR_W-1:0] addr_q, addr_n;
   logic                  corrupt_q, corrupt_n;
   logic [HDR_LEN_W-1:0]  idx, idx_n;
   logic [7:0]            acc, acc_n;
   logic [7:0]            data_q, data_n;
   logic                  vld_q, vld_n;
   logic                  done_q, done_n;
   logic                  err_q, err_n;
   logic                  wr_ready_q, wr_ready_n;

   logic                  buf_we, buf_clr, last, start_bad;
   logic [HDR_LEN_W-1:0]  rd_idx, buf_count, count_n;
   logic [7:0]            rd_data, hdr;

   pkt_byte_buffer #(.MAX_LEN(MAX_LEN)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .clr     (buf_clr),
      .wr_en   (buf_we),
      .wr_data (bus.wr_data),
      .rd_idx  (rd_idx),
      .rd_data (rd_data),
      .count   (buf_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         len_q      <= '0;
         addr_q     <= '0;
         corrupt_q  <= 1'b0;
         idx        <= '0;
         acc        <= '0;
         data_q     <= '0;
         vld_q      <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         wr_ready_q <= 1'b1;
      end else begin
         state      <= state_n;
         len_q      <= len_n;
         addr_q     <= addr_n;
         corrupt_q  <= corrupt_n;
         idx        <= idx_n;
         acc        <= acc_n;
         data_q     <= data_n;
         vld_q      <= vld_n;
         done_q     <= done_n;
         err_q      <= err_n;
         wr_ready_q <= wr_ready_n;
      end
   end

   always_comb begin
      state_n   = state;
      len_n     = len_q;
      addr_n    = addr_q;
      corrupt_n = corrupt_q;
      idx_n     = idx;
      acc_n     = acc;
      data_n    = data_q;
      vld_n     = vld_q;
      done_n    = 1'b0;
      err_n     = 1'b0;
      buf_we    = 1'b0;
      buf_clr   = 1'b0;
      hdr       = mk_header(bus.payload_len, bus.dest_addr);
      last      = (idx == len_q - 1'b1);
      start_bad = (bus.payload_len == '0) || (bus.payload_len > buf_count) ||
                  (bus.dest_addr == 2'd3);
      // Prefetch the byte that follows the one currently on data_out.
      rd_idx    = (state == ST_PAYLOAD && !last) ? idx + 1'b1 : '0;

      case (state)
         ST_IDLE: begin
            buf_we = bus.wr_en && wr_ready_q;
            if (bus.start) begin
               if (start_bad) begin
                  err_n = 1'b1;
               end else begin
                  len_n     = bus.payload_len;
                  addr_n    = bus.dest_addr;
                  corrupt_n = bus.corrupt_parity;
                  acc_n     = hdr;
                  data_n    = hdr;
                  vld_n     = 1'b1;
                  state_n   = ST_HEADER;
               end
            end
         end
         ST_HEADER: begin
            if (!bus.busy) begin
               idx_n   = '0;
               data_n  = rd_data;
               state_n = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (!bus.busy) begin
               acc_n = acc ^ data_q;
               if (last) begin
                  data_n  = acc ^ data_q ^ (corrupt_q ? 8'hFF : 8'h00);
                  vld_n   = 1'b0;
                  state_n = ST_PARITY;
               end else begin
                  idx_n  = idx + 1'b1;
                  data_n = rd_data;
               end
            end
         end
         ST_PARITY: begin
            if (!bus.busy) begin
               data_n  = '0;
               done_n  = 1'b1;
               state_n = ST_GAP;
            end
         end
         ST_GAP: begin
            buf_clr = 1'b1;
            idx_n   = '0;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase

      count_n    = buf_clr ? '0 : (buf_we ? buf_count + 1'b1 : buf_count);
      wr_ready_n = (state_n == ST_IDLE) && (count_n < MAX_CNT);
   end

   assign bus.wr_ready  = wr_ready_q;
   assign bus.pkt_valid = vld_q;
   assign bus.data_out  = data_q;
   assign bus.done      = done_q;
   assign bus.req_err   = err_q;

endmodule

// File: tb/tb_router_pkt_source.sv
// Bench for router_pkt_source: directed sequences, a start-rejection table and
// randomized packets checked against a beat-list model of the packet format.
module tb_router_pkt_source;
   import router_pkt_source_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   router_pkt_source_if bus();

   router_pkt_source #(.MAX_LEN(63)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_buf[$];
   int         stall_a[0:65];
   logic [7:0] last_hdr, last_par;

   typedef struct {
      logic [5:0] len;
      logic [1:0] addr;
      logic       exp_err;
      logic       exp_vld;
   } rej_vec_t;

   rej_vec_t rej_tab[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wr_en          = 1'b0;
      bus.wr_data        = '0;
      bus.start          = 1'b0;
      bus.dest_addr      = '0;
      bus.payload_len    = '0;
      bus.corrupt_parity = 1'b0;
      bus.busy           = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b);
      bit take;
      take        = (model_buf.size() < 63);
      bus.wr_en   = 1'b1;
      bus.wr_data = b;
      step();
      bus.wr_en   = 1'b0;
      if (take) model_buf.push_back(b);
      check("wr_ready", 32'(bus.wr_ready), 32'(model_buf.size() < 63));
   endtask

   task automatic try_start(input logic [5:0] len, input logic [1:0] addr,
                            input logic exp_err, input logic exp_vld);
      bus.start       = 1'b1;
      bus.payload_len = len;
      bus.dest_addr   = addr;
      step();
      bus.start = 1'b0;
      check("req_err_pulse", 32'(bus.req_err), 32'(exp_err));
      check("rej_pkt_valid", 32'(bus.pkt_valid), 32'(exp_vld));
      step();
      check("req_err_clear", 32'(bus.req_err), 32'h0);
   endtask

   // Expected stream: header, len payload bytes, parity; beat b is held for
   // stall_a[b] extra cycles, then one GAP cycle with done.
   task automatic send_packet(input int len, input logic [1:0] addr,
                              input bit corrupt, input bit noise);
      logic [7:0] beats[0:65];
      logic [7:0] par;
      logic [5:0] l6;
      l6       = 6'(len);
      beats[0] = {l6, addr};
      par      = beats[0];
      for (int i = 0; i < len; i++) begin
         beats[i+1] = model_buf[i];
         par ^= model_buf[i];
      end
      if (corrupt) par ^= 8'hFF;
      beats[len+1] = par;

      bus.start          = 1'b1;
      bus.payload_len    = l6;
      bus.dest_addr      = addr;
      bus.corrupt_parity = corrupt;
      step();
      bus.start = 1'b0;
      for (int b = 0; b <= len + 1; b++) begin
         for (int s = 0; s <= stall_a[b]; s++) begin
            check("beat_data", 32'(bus.data_out), 32'(beats[b]));
            check("beat_valid", 32'(bus.pkt_valid), 32'(b <= len));
            check("beat_done", 32'(bus.done), 32'h0);
            check("beat_req_err", 32'(bus.req_err), 32'h0);
            check("beat_wr_ready", 32'(bus.wr_ready), 32'h0);
            if (b == 0) last_hdr = bus.data_out;
            if (b == len + 1) last_par = bus.data_out;
            bus.busy = (s < stall_a[b]);
            if (noise) begin
               bus.start       = 1'($urandom);
               bus.payload_len = 6'($urandom);
               bus.dest_addr   = 2'($urandom);
               bus.wr_en       = 1'($urandom);
               bus.wr_data     = 8'($urandom);
            end
            step();
         end
      end
      bus.busy = 1'b0;
      check("gap_done", 32'(bus.done), 32'h1);
      check("gap_valid", 32'(bus.pkt_valid), 32'h0);
      check("gap_data", 32'(bus.data_out), 32'h0);
      step();
      idle_inputs();
      check("idle_done", 32'(bus.done), 32'h0);
      check("idle_req_err", 32'(bus.req_err), 32'h0);
      check("idle_wr_ready", 32'(bus.wr_ready), 32'h1);
      model_buf.delete();
      foreach (stall_a[i]) stall_a[i] = 0;
   endtask

   initial begin
      int n, len;
      foreach (stall_a[i]) stall_a[i] = 0;
      rej_tab[0] = '{len: 6'd5,  addr: 2'd0, exp_err: 1'b1, exp_vld: 1'b0};
      rej_tab[1] = '{len: 6'd4,  addr: 2'd1, exp_err: 1'b1, exp_vld: 1'b0};
      rej_tab[2] = '{len: 6'd3,  addr: 2'd3, exp_err: 1'b1, exp_vld: 1'b0};
      rej_tab[3] = '{len: 6'd0,  addr: 2'd1, exp_err: 1'b1, exp_vld: 1'b0};
      rej_tab[4] = '{len: 6'd0,  addr: 2'd3, exp_err: 1'b1, exp_vld: 1'b0};
      rej_tab[5] = '{len: 6'd63, addr: 2'd2, exp_err: 1'b1, exp_vld: 1'b0};

      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("rst_pkt_valid", 32'(bus.pkt_valid), 32'h0);
      check("rst_data_out", 32'(bus.data_out), 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);
      check("rst_req_err", 32'(bus.req_err), 32'h0);
      check("rst_wr_ready", 32'(bus.wr_ready), 32'h1);

      // Basic packet
      write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
      send_packet(3, 2'd2, 1'b0, 1'b0);
      check("basic_hdr", 32'(last_hdr), 32'h0E);
      check("basic_par", 32'(last_par), 32'h0E);

      // Two busy cycles on byte 8'h22
      write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
      stall_a[2] = 2;
      send_packet(3, 2'd2, 1'b0, 1'b0);
      check("stall_par", 32'(last_par), 32'h0E);

      // Corrupted parity
      write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
      send_packet(3, 2'd2, 1'b1, 1'b0);
      check("corrupt_par", 32'(last_par), 32'hF1);

      // Rejected starts leave the buffer intact
      write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
      for (int i = 0; i < 6; i++)
         try_start(rej_tab[i].len, rej_tab[i].addr, rej_tab[i].exp_err, rej_tab[i].exp_vld);
      send_packet(3, 2'd1, 1'b0, 1'b0);

      // Full buffer, one refused extra write
      for (int i = 0; i < 63; i++) write_byte(8'(i));
      write_byte(8'hAA);
      send_packet(63, 2'd0, 1'b0, 1'b0);
      check("full_hdr", 32'(last_hdr), 32'hFC);
      check("full_par", 32'(last_par), 32'hC3);

      // Reset in the middle of the payload
      write_byte(8'h44); write_byte(8'h55); write_byte(8'h66);
      bus.start       = 1'b1;
      bus.payload_len = 6'd3;
      bus.dest_addr   = 2'd1;
      step();
      bus.start = 1'b0;
      step();
      step();
      check("pre_rst_data", 32'(bus.data_out), 32'h55);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_valid", 32'(bus.pkt_valid), 32'h0);
      check("mid_rst_data", 32'(bus.data_out), 32'h0);
      check("mid_rst_done", 32'(bus.done), 32'h0);
      check("mid_rst_wr_ready", 32'(bus.wr_ready), 32'h1);
      model_buf.delete();
      write_byte(8'h77); write_byte(8'h88); write_byte(8'h99);
      send_packet(3, 2'd1, 1'b0, 1'b0);

      // Randomized packets with stalls and ignored traffic during transmission
      for (int p = 0; p < 25; p++) begin
         n = $urandom_range(1, 63);
         for (int i = 0; i < n; i++) write_byte(8'($urandom));
         if ($urandom_range(0, 3) == 0) begin
            if (n < 63) try_start(6'(n + 1), 2'($urandom_range(0, 2)), 1'b1, 1'b0);
            else        try_start(6'(n), 2'd3, 1'b1, 1'b0);
         end
         len = $urandom_range(1, n);
         for (int b = 0; b <= len + 1; b++)
            stall_a[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         send_packet(len, 2'($urandom_range(0, 2)), 1'($urandom), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
